// File: rtl/cdb_arbiter.sv
// Common-data-bus write-back arbiter: per-FU completion FIFOs, round-robin grant,
// registered single-entry broadcast per cycle and per-source issue hold flags.
package cdb_arbiter_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] order;
    logic        trap;
  } cdb_entry_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HOLD_SLACK = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NUM_SRC-1:0]         src_valid_i,
  input  cdb_entry_t [NUM_SRC-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]         src_hold_o,
  output logic                       cdb_valid_o,
  output cdb_entry_t                 cdb_data_o,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src_o,
  output logic                       overflow_o
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cdb_entry_t       mem_q    [NUM_SRC][DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_q    [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q;
  cdb_entry_t       cdb_data_q;
  logic [SRC_W-1:0] cdb_src_q;
  logic             overflow_q;

  logic [NUM_SRC-1:0] req, pop, push_ok;
  logic               gnt_valid, hi_hit;
  logic [SRC_W-1:0]   gnt_idx, hi_idx, lo_idx;
  logic               drop_any;
  cdb_entry_t         head;

  // Request, pop, accepted-push and hold vectors
  always_comb begin
    req        = '0;
    pop        = '0;
    push_ok    = '0;
    src_hold_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i]        = (cnt_q[i] != '0);
      pop[i]        = gnt_valid && (gnt_idx == SRC_W'(i));
      push_ok[i]    = src_valid_i[i] && ((cnt_q[i] != CNT_W'(DEPTH)) || pop[i]);
      src_hold_o[i] = (cnt_q[i] >= CNT_W'(DEPTH - HOLD_SLACK));
    end
    drop_any = |(src_valid_i & ~push_ok);
  end

  // Round-robin: lowest requester at or above rr_ptr, else lowest requester overall
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    gnt_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_valid = 1'b1;
        lo_idx    = SRC_W'(i);
        if (SRC_W'(i) >= rr_ptr_q) begin
          hi_hit = 1'b1;
          hi_idx = SRC_W'(i);
        end
      end
    end
    gnt_idx  = hi_hit ? hi_idx : lo_idx;
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      rr_ptr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end
    head = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
  end

  // FIFO storage is not reset; only the pointers and counts define validity
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!rst_i && !flush_i && push_ok[i]) begin
        mem_q[i][wr_ptr_q[i]] <= src_data_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        if (push_ok[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (!push_ok[i] && pop[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= gnt_valid;
      cdb_data_q  <= gnt_valid ? head : '0;
      cdb_src_q   <= gnt_valid ? gnt_idx : '0;
    end
    // Sticky: survives flush, cleared only by reset
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if (!flush_i && drop_any) begin
      overflow_q <= 1'b1;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_src_o   = cdb_src_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-source expected queues filled at drive time and
// drained by a broadcast monitor, plus a grant-order table and timed sequences.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned NS = 4;

  logic             clk, rst, flush;
  logic [NS-1:0]    src_valid;
  cdb_entry_t [NS-1:0] src_data;
  logic [NS-1:0]    src_hold;
  logic             cdb_valid;
  cdb_entry_t       cdb_data;
  logic [1:0]       cdb_src;
  logic             overflow;

  cdb_arbiter #(.NUM_SRC(NS), .DEPTH(8), .HOLD_SLACK(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .src_valid_i (src_valid),
    .src_data_i  (src_data),
    .src_hold_o  (src_hold),
    .cdb_valid_o (cdb_valid),
    .cdb_data_o  (cdb_data),
    .cdb_src_o   (cdb_src),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int tag_ctr = 1;
  cdb_entry_t exp_q [NS][$];
  cdb_entry_t mon_e;

  typedef struct {
    logic [3:0]      mask;
    int              n;
    logic [3:0][1:0] srcs;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h required %0h at t=%0t", name, got, exp, $time);
  endtask

  function automatic cdb_entry_t mk(input int s, input int tag);
    cdb_entry_t e;
    e.rd    = 5'(s + 3);
    e.data  = {16'(tag), 16'h1230 + 16'(2 * s)};
    e.pc    = 32'(tag * 4);
    e.inst  = 32'h13 ^ 32'(tag);
    e.order = 32'(tag);
    e.trap  = 1'b0;
    return e;
  endfunction

  function automatic bit sb_empty();
    for (int i = 0; i < NS; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sb_total();
    int t = 0;
    for (int i = 0; i < NS; i++) t += exp_q[i].size();
    return t;
  endfunction

  function automatic bit is_drop(input int s, input int c);
    return (c == 10 && (s == 2 || s == 3)) || (c == 11 && (s == 0 || s == 1 || s == 3));
  endfunction

  task automatic clear_sb();
    for (int i = 0; i < NS; i++) exp_q[i].delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of completions; sources in rec are expected to be broadcast later
  task automatic drive(input logic [3:0] mask, input logic [3:0] rec, input bit zero_tag);
    src_valid = mask;
    for (int i = 0; i < NS; i++) begin
      src_data[i] = mk(i, zero_tag ? 0 : tag_ctr);
      if (mask[i] && rec[i]) exp_q[i].push_back(src_data[i]);
    end
    tag_ctr++;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, 256'(cdb_valid), 256'(1'b0));
    chk({name, "_data"},  256'(cdb_data),  256'(0));
    chk({name, "_src"},   256'(cdb_src),   256'(0));
    chk({name, "_hold"},  256'(src_hold),  256'(0));
    chk({name, "_ovf"},   256'(overflow),  256'(1'b0));
  endtask

  // Broadcast monitor: each valid cycle must match the head of that source's queue
  always @(negedge clk) begin
    if (cdb_valid === 1'b1) begin
      if (exp_q[cdb_src].size() == 0) begin
        checks++;
        $display("FAIL unexpected_bcast: src %0d data %0h with nothing pending at t=%0t",
                 cdb_src, cdb_data, $time);
      end else begin
        mon_e = exp_q[cdb_src].pop_front();
        chk("bcast_data", 256'(cdb_data), 256'(mon_e));
      end
    end else begin
      chk("idle_data", 256'(cdb_data), 256'(0));
      chk("idle_src",  256'(cdb_src),  256'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [3:0] rec;
    int cyc;
    rst = 1'b1; flush = 1'b0; src_valid = '0; src_data = '0;

    vecs[0] = '{4'b0100, 1, {2'd0, 2'd0, 2'd0, 2'd2}};
    vecs[1] = '{4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[2] = '{4'b1010, 2, {2'd0, 2'd0, 2'd3, 2'd1}};
    vecs[3] = '{4'b1001, 2, {2'd0, 2'd0, 2'd3, 2'd0}};
    vecs[4] = '{4'b1000, 1, {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[5] = '{4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}};

    // Reset with random completions: nothing may be captured
    for (int c = 0; c < 2; c++) begin
      drive(4'($urandom_range(0, 15)), 4'b0000, 1'b0);
      tick();
      chk_reset_outputs("rst");
    end
    rst = 1'b0;
    src_valid = '0;
    tick();
    chk_reset_outputs("rst_rel");
    tick();
    chk("rst_rel2_valid", 256'(cdb_valid), 256'(1'b0));

    // Grant-order table: one-shot arrival right after a flush (rr_ptr = 0)
    for (int v = 0; v < 6; v++) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(vecs[v].mask, vecs[v].mask, v == 0);
      tick();
      src_valid = '0;
      for (int k = 1; k <= vecs[v].n + 2; k++) begin
        chk("tbl_valid", 256'(cdb_valid), 256'(k >= 2 && k < 2 + vecs[v].n));
        if (k >= 2 && k < 2 + vecs[v].n) begin
          chk("tbl_src", 256'(cdb_src), 256'(vecs[v].srcs[k - 2]));
        end
        if (v == 0 && k == 2) begin
          chk("single_rd",   256'(cdb_data.rd),   256'(5));
          chk("single_data", 256'(cdb_data.data), 256'(32'h1234));
        end
        tick();
      end
      chk("tbl_drained", 256'(sb_empty()), 256'(1'b1));
    end

    // Fairness: sources 0 and 3 stream together and must alternate 0,3,0,3...
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      drive((k < 14) ? 4'b1001 : 4'b0000, 4'b1001, 1'b0);
      tick();
      cyc = k + 1;
      if (cyc >= 2 && cyc <= 29) begin
        chk("fair_valid", 256'(cdb_valid), 256'(1'b1));
        chk("fair_src",   256'(cdb_src),   256'((cyc % 2 == 0) ? 0 : 3));
      end else if (cyc == 30) begin
        chk("fair_end_valid", 256'(cdb_valid), 256'(1'b0));
      end
    end
    src_valid = '0;
    chk("fair_ovf",     256'(overflow),   256'(1'b0));
    chk("fair_drained", 256'(sb_empty()), 256'(1'b1));

    // Congestion: all four sources stream for 12 cycles; some pushes are dropped
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NS; i++) rec[i] = !is_drop(i, c);
      drive(4'b1111, rec, 1'b0);
      tick();
      cyc = c + 1;
      if (cyc == 5)  chk("hold_c5",  256'(src_hold), 256'(4'b0000));
      if (cyc == 6)  chk("hold_c6",  256'(src_hold), 256'(4'b1110));
      if (cyc == 7)  chk("hold_c7",  256'(src_hold), 256'(4'b1111));
      if (cyc == 10) chk("ovf_c10",  256'(overflow), 256'(1'b0));
      if (cyc == 11) chk("ovf_c11",  256'(overflow), 256'(1'b1));
    end
    src_valid = '0;
    for (int w = 0; w < 60 && !sb_empty(); w++) tick();
    chk("cong_drained", 256'(sb_empty()), 256'(1'b1));
    tick();
    chk("cong_idle_hold", 256'(src_hold), 256'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ovf_after_flush", 256'(overflow), 256'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_after_rst", 256'(overflow), 256'(1'b0));
    tick();

    // Flush mid-stream: queued entries vanish, later completion still flows
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      tick();
    end
    flush = 1'b1;
    drive(4'b1111, 4'b0000, 1'b0);
    tick();
    flush = 1'b0;
    src_valid = '0;
    chk("flush_pending", 256'(sb_total()), 256'(10));
    clear_sb();
    chk("flush_valid", 256'(cdb_valid), 256'(1'b0));
    chk("flush_hold",  256'(src_hold),  256'(0));
    tick();
    drive(4'b0010, 4'b0010, 1'b0);
    tick();
    src_valid = '0;
    chk("pf_c6_valid", 256'(cdb_valid), 256'(1'b0));
    tick();
    chk("pf_c7_valid", 256'(cdb_valid), 256'(1'b1));
    chk("pf_c7_src",   256'(cdb_src),   256'(1));
    tick();
    chk("pf_c8_valid", 256'(cdb_valid), 256'(1'b0));
    chk("pf_drained",  256'(sb_empty()), 256'(1'b1));

    // Reset in the middle of traffic drops all in-flight entries
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      tick();
    end
    rst = 1'b1;
    drive(4'b1111, 4'b0000, 1'b0);
    tick();
    rst = 1'b0;
    src_valid = '0;
    clear_sb();
    chk_reset_outputs("midrst");
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrst_quiet", 256'(cdb_valid), 256'(1'b0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
